// File: rtl/master_addr_fifo_arbiter.sv
// Round-robin arbiter with burst lock for the write port of the AXI4 master address FIFO.
// Optional build macro ADDR_ARB_TAG_EN: overwrite the top ID_WIDTH data bits with the owner index.
module master_addr_fifo_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 72,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ-1:0]            i_req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
   input  logic                          i_fifo_wr_full,
   input  logic                          i_fifo_almost_full,
   output logic [ID_WIDTH-1:0]           o_grant_id,
   output logic                          o_busy
);

   // state  | meaning
   // S_IDLE | no owner; pick the next requester from r_rr_ptr
   // S_LOCK | r_grant_id owns the port until its req_last descriptor transfers
   typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic [ID_WIDTH-1:0]   r_grant_id;
   logic [ID_WIDTH-1:0]   w_pick;
   logic                  r_wr_en;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  w_space;
   logic                  w_any_valid;
   logic                  w_xfer;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_desc;
   logic [DATA_WIDTH-1:0] w_wr_data_nxt;

   // almost_full leaves room for the descriptor held in the output register
   assign w_space     = !i_fifo_wr_full && !i_fifo_almost_full;
   assign w_any_valid = |i_req_valid;
   assign w_desc      = i_req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign w_last      = i_req_last[r_grant_id];
   assign w_xfer      = i_req_valid[r_grant_id] && o_req_ready[r_grant_id];

`ifdef ADDR_ARB_TAG_EN
   assign w_wr_data_nxt = {r_grant_id, w_desc[DATA_WIDTH-ID_WIDTH-1:0]};
`else
   assign w_wr_data_nxt = w_desc;
`endif

   // Scan from the farthest offset down so the nearest valid index at or after r_rr_ptr wins.
   always_comb begin : p_pick
      logic [ID_WIDTH-1:0] v_idx;
      v_idx  = '0;
      w_pick = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         v_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (i_req_valid[v_idx]) w_pick = v_idx;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_any_valid)     w_state_nxt = S_LOCK;
         S_LOCK: if (w_xfer && w_last) w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      if (r_state == S_LOCK) o_req_ready[r_grant_id] = w_space;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= '0;
      end else begin
         r_wr_en <= w_xfer;
         if (w_xfer) r_wr_data <= w_wr_data_nxt;
         if (r_state == S_IDLE && w_any_valid) r_grant_id <= w_pick;
         if (w_xfer && w_last)
            r_rr_ptr <= (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
   end

   assign o_fifo_wr_en   = r_wr_en;
   assign o_fifo_wr_data = r_wr_data;
   assign o_grant_id     = r_grant_id;
   assign o_busy         = (r_state == S_LOCK);

endmodule
